// File: rtl/board_pkg.sv
// Shared types and constants for the board reset / input conditioning block.
package board_pkg;

  localparam int unsigned SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } state_t;

endpackage

// File: rtl/key_debounce.sv
// Single push-button conditioning: 2-FF synchroniser followed by a saturating-count debouncer.
module key_debounce
  import board_pkg::*;
#(
  parameter int unsigned DEBOUNCE_BITS = 16,
  parameter bit          INVERT        = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic key_raw,
  output logic state,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0]   sync_q;
  logic                     synced;
  logic [DEBOUNCE_BITS-1:0] cnt;

  // Polarity is normalised before synchronising so 0 always means "not pressed".
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], key_raw ^ INVERT};
    end
  end

  assign synced = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      state <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (synced == state) begin
        cnt <= '0;
      end else if (cnt == '1) begin
        state <= synced;
        cnt   <= '0;
        rise  <= synced;
        fall  <= ~synced;
      end else begin
        cnt <= cnt + DEBOUNCE_BITS'(1);
      end
    end
  end

endmodule

// File: rtl/board_reset_seq.sv
// Board reset sequencer: synchronises locks and keys, debounces keys, and releases
// a chain of staged resets at a fixed spacing once all PLLs are locked.
module board_reset_seq
  import board_pkg::*;
#(
  parameter int unsigned NUM_KEYS         = 2,
  parameter int unsigned NUM_LOCKS        = 1,
  parameter int unsigned NUM_STAGES       = 3,
  parameter int unsigned DEBOUNCE_BITS    = 16,
  parameter int unsigned STAGE_DELAY_BITS = 8,
  parameter int unsigned KEY_ACTIVE_LOW   = 1,
  parameter int unsigned RESET_KEY        = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_KEYS-1:0]   keys_in,
  input  logic [NUM_LOCKS-1:0]  pll_locked,
  input  logic                  soft_reset_req,
  output logic [NUM_KEYS-1:0]   keys_db,
  output logic [NUM_KEYS-1:0]   key_pressed,
  output logic [NUM_KEYS-1:0]   key_released,
  output logic [NUM_STAGES-1:0] rst_out,
  output logic                  all_ready,
  output logic                  lock_lost
);

  localparam int unsigned IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  logic [NUM_LOCKS-1:0]        lock_s1, lock_s2;
  logic                        locks_ok, rkey_held, ok;
  logic                        cnt_wrap, last_idx;
  state_t                      state, state_n;
  logic [STAGE_DELAY_BITS-1:0] cnt, cnt_d;
  logic [IDX_W-1:0]            idx, idx_d;
  logic [NUM_STAGES-1:0]       rst_d;
  logic                        rdy_d, lost_d;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_debounce #(
      .DEBOUNCE_BITS(DEBOUNCE_BITS),
      .INVERT       (KEY_ACTIVE_LOW != 0)
    ) u_db (
      .clk    (clk),
      .reset  (reset),
      .key_raw(keys_in[k]),
      .state  (keys_db[k]),
      .rise   (key_pressed[k]),
      .fall   (key_released[k])
    );
  end

  if (RESET_KEY < NUM_KEYS) begin : g_rkey
    assign rkey_held = keys_db[RESET_KEY];
  end else begin : g_no_rkey
    assign rkey_held = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lock_s1 <= '0;
      lock_s2 <= '0;
    end else begin
      lock_s1 <= pll_locked;
      lock_s2 <= lock_s1;
    end
  end

  assign locks_ok = &lock_s2;
  assign ok       = locks_ok & ~rkey_held & ~soft_reset_req;
  assign cnt_wrap = (cnt == '1);
  assign last_idx = (idx == IDX_W'(NUM_STAGES - 1));

  // State and sequencing registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= HOLD;
      cnt       <= '0;
      idx       <= '0;
      rst_out   <= '1;
      all_ready <= 1'b0;
      lock_lost <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_d;
      idx       <= idx_d;
      rst_out   <= rst_d;
      all_ready <= rdy_d;
      lock_lost <= lost_d;
    end
  end

  // Next-state: loss of ok overrides any pending stage release.
  always_comb begin
    state_n = state;
    if (!ok) begin
      state_n = HOLD;
    end else begin
      case (state)
        HOLD: begin
          if (cnt_wrap) begin
            if (NUM_STAGES == 1) state_n = RUN;
            else                 state_n = RELEASE;
          end
        end
        RELEASE: if (cnt_wrap && last_idx) state_n = RUN;
        RUN:     state_n = RUN;
        default: state_n = HOLD;
      endcase
    end
  end

  // Next values of the registered outputs and sequencing counters.
  always_comb begin
    cnt_d  = cnt;
    idx_d  = idx;
    rst_d  = rst_out;
    rdy_d  = all_ready;
    lost_d = lock_lost;
    if (!ok) begin
      cnt_d = '0;
      idx_d = '0;
      rst_d = '1;
      rdy_d = 1'b0;
      if (!locks_ok && state != HOLD) lost_d = 1'b1;
    end else begin
      case (state)
        HOLD: begin
          cnt_d = cnt + STAGE_DELAY_BITS'(1);
          rst_d = '1;
          rdy_d = 1'b0;
          if (cnt_wrap) begin
            rst_d = ~NUM_STAGES'(1);
            idx_d = IDX_W'(1);
            if (NUM_STAGES == 1) rdy_d = 1'b1;
          end
        end
        RELEASE: begin
          cnt_d = cnt + STAGE_DELAY_BITS'(1);
          if (cnt_wrap) begin
            rst_d = rst_out & ~(NUM_STAGES'(1) << idx);
            idx_d = idx + IDX_W'(1);
            if (last_idx) rdy_d = 1'b1;
          end
        end
        RUN: begin
          cnt_d = '0;
          rdy_d = 1'b1;
        end
        default: begin
          cnt_d = '0;
          rst_d = '1;
          rdy_d = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_board_reset_seq.sv
// Directed self-checking bench for board_reset_seq (D=8, 16-cycle debounce, 3 stages).
module tb_board_reset_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] keys_in;
  logic [1:0] pll_locked;
  logic       soft_reset_req;
  logic [1:0] keys_db, key_pressed, key_released;
  logic [2:0] rst_out;
  logic       all_ready, lock_lost;

  int n_checks = 0;
  int n_fail   = 0;

  board_reset_seq #(
    .NUM_KEYS        (2),
    .NUM_LOCKS       (2),
    .NUM_STAGES      (3),
    .DEBOUNCE_BITS   (4),
    .STAGE_DELAY_BITS(3),
    .KEY_ACTIVE_LOW  (1),
    .RESET_KEY       (0)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .keys_in       (keys_in),
    .pll_locked    (pll_locked),
    .soft_reset_req(soft_reset_req),
    .keys_db       (keys_db),
    .key_pressed   (key_pressed),
    .key_released  (key_released),
    .rst_out       (rst_out),
    .all_ready     (all_ready),
    .lock_lost     (lock_lost)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Power-up
    reset = 1'b1; keys_in = 2'b11; pll_locked = 2'b00; soft_reset_req = 1'b0;
    step(5);
    chk("rst_rst_out", 32'(rst_out), 32'h7);
    chk("rst_all_ready", 32'(all_ready), 32'h0);
    chk("rst_lock_lost", 32'(lock_lost), 32'h0);
    chk("rst_keys_db", 32'(keys_db), 32'h0);
    chk("rst_pressed", 32'(key_pressed), 32'h0);
    chk("rst_released", 32'(key_released), 32'h0);
    reset = 1'b0; pll_locked = 2'b11;                 // cycle 0
    step(9);  chk("pu_c9", 32'(rst_out), 32'h7);
    step(1);  chk("pu_c10", 32'(rst_out), 32'h6);
    step(7);  chk("pu_c17", 32'(rst_out), 32'h6);
    step(1);  chk("pu_c18", 32'(rst_out), 32'h4);
    step(7);  chk("pu_c25", 32'(rst_out), 32'h4);
    chk("pu_c25_rdy", 32'(all_ready), 32'h0);
    step(1);  chk("pu_c26", 32'(rst_out), 32'h0);
    chk("pu_c26_rdy", 32'(all_ready), 32'h1);
    chk("pu_lost", 32'(lock_lost), 32'h0);

    // Staggered locks
    reset = 1'b1; pll_locked = 2'b00;
    step(2);
    reset = 1'b0; pll_locked = 2'b01;                 // cycle 0
    step(20); chk("stag_c20", 32'(rst_out), 32'h7);
    pll_locked = 2'b11;
    step(9);  chk("stag_c29", 32'(rst_out), 32'h7);
    step(1);  chk("stag_c30", 32'(rst_out), 32'h6);

    // Key bounce on key 1: short glitch ignored, steady press accepted
    keys_in = 2'b01;
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("glitch_db", 32'(keys_db), 32'h0);
      chk("glitch_pr", 32'(key_pressed), 32'h0);
    end
    keys_in = 2'b11;
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk("glitch_tail_db", 32'(keys_db), 32'h0);
      chk("glitch_tail_pr", 32'(key_pressed), 32'h0);
    end
    keys_in = 2'b01;
    step(17); chk("press_c17_db", 32'(keys_db), 32'h0);
    chk("press_c17_pr", 32'(key_pressed), 32'h0);
    step(1);  chk("press_c18_db", 32'(keys_db), 32'h2);
    chk("press_c18_pr", 32'(key_pressed), 32'h2);
    step(1);  chk("press_c19_pr", 32'(key_pressed), 32'h0);
    chk("press_c19_db", 32'(keys_db), 32'h2);
    keys_in = 2'b11;
    step(18); chk("rel_db", 32'(keys_db), 32'h0);
    chk("rel_pulse", 32'(key_released), 32'h2);

    // Lock loss in RUN
    chk("run_rst_out", 32'(rst_out), 32'h0);
    chk("run_rdy", 32'(all_ready), 32'h1);
    chk("run_lost", 32'(lock_lost), 32'h0);
    pll_locked = 2'b01;                               // cycle 0
    step(1);  pll_locked = 2'b11;
    step(1);  chk("ll_c2", 32'(rst_out), 32'h0);
    step(1);  chk("ll_c3", 32'(rst_out), 32'h7);
    chk("ll_c3_rdy", 32'(all_ready), 32'h0);
    chk("ll_c3_lost", 32'(lock_lost), 32'h1);
    step(7);  chk("ll_c10", 32'(rst_out), 32'h7);
    step(1);  chk("ll_c11", 32'(rst_out), 32'h6);
    step(16); chk("ll_c27", 32'(rst_out), 32'h0);
    chk("ll_c27_rdy", 32'(all_ready), 32'h1);
    chk("ll_c27_lost", 32'(lock_lost), 32'h1);

    // Soft reset pulse in RUN
    soft_reset_req = 1'b1;                            // cycle 0
    step(1);  soft_reset_req = 1'b0;
    chk("soft_c1", 32'(rst_out), 32'h7);
    chk("soft_c1_rdy", 32'(all_ready), 32'h0);
    chk("soft_c1_lost", 32'(lock_lost), 32'h1);

    // Reset key pressed so its debounced press lands mid-RELEASE
    step(1);  keys_in = 2'b10;                        // cycle 2
    step(6);  chk("soft_c8", 32'(rst_out), 32'h7);
    step(1);  chk("soft_c9", 32'(rst_out), 32'h6);
    step(8);  chk("rk_c17", 32'(rst_out), 32'h4);
    step(3);  chk("rk_c20", 32'(rst_out), 32'h4);
    chk("rk_c20_db", 32'(keys_db), 32'h1);
    chk("rk_c20_pr", 32'(key_pressed), 32'h1);
    step(1);  chk("rk_c21", 32'(rst_out), 32'h7);
    chk("rk_c21_rdy", 32'(all_ready), 32'h0);
    chk("rk_c21_lost", 32'(lock_lost), 32'h1);
    step(10); chk("rk_c31_held", 32'(rst_out), 32'h7);
    keys_in = 2'b11;                                  // cycle 31
    step(18); chk("rk_c49_db", 32'(keys_db), 32'h0);
    chk("rk_c49_rel", 32'(key_released), 32'h1);
    chk("rk_c49", 32'(rst_out), 32'h7);
    step(7);  chk("rk_c56", 32'(rst_out), 32'h7);
    step(1);  chk("rk_c57", 32'(rst_out), 32'h6);

    // Lock drop coinciding with the stage 1 release edge
    step(5);  pll_locked = 2'b10;                     // cycle 62
    step(1);  pll_locked = 2'b11;
    step(1);  chk("race_c64", 32'(rst_out), 32'h6);
    step(1);  chk("race_c65", 32'(rst_out), 32'h7);
    chk("race_c65_lost", 32'(lock_lost), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
